fifo_rd_arbiter: RTL and testbench
==================================

Name: fifo_rd_arbiter

Overview:
- Round-robin read scheduler that drains NCH async-FIFO read sides into one downstream stream, all in the read clock domain.
- Each FIFO presents its registered empty flag and combinational read data; this block drives the per-FIFO pop strobes.
- A grant is held for up to BURST words, then released for re-arbitration.
- Output is one registered valid/ready stage tagged with the source channel.

Parameters:
- NCH, 4, number of FIFO channels (≥2).
- DSIZE, 8, data word width.
- BURST, 4, maximum pops per grant (≥1).
- Derived: CW = clog2(NCH); BW = clog2(BURST+1).

Ports:
- rclk  input  1  read-domain clock, all logic on posedge.
- rrst  input  1  synchronous reset, active-high.
- ch_en  input  NCH  per-channel enable; a disabled channel is never granted.
- rempty  input  NCH  per-FIFO empty flag (registered; reflects any pop on the next cycle).
- rdata  input  NCH*DSIZE  per-FIFO head word; channel i occupies bits [i*DSIZE +: DSIZE].
- rpop  output  NCH  per-FIFO pop strobe, one-hot or zero, combinational.
- out_data  output  DSIZE  registered output word.
- out_ch  output  CW  channel index of out_data.
- out_valid  output  1  out_data/out_ch valid.
- out_ready  input  1  downstream accepts when out_valid & out_ready.
- busy  output  1  high while state is XFER.

Behaviour:
- Reset (rrst sampled high): state=IDLE, gnt=0, last=NCH-1, beat=0, out_valid=0, out_data=0, out_ch=0, busy=0.
- rpop is forced to 0 while rrst is high, including mid-burst.
- A word already in the output register at reset is discarded.
- Definitions:
  - elig = ch_en & ~rempty.
  - adv = ~out_valid | out_ready (output register can load).
- IDLE:
  - If elig != 0, select the first set bit of elig scanning circularly from last+1. Load gnt, clear beat, go to XFER.
  - No pop in IDLE: the arbitration cycle is a one-cycle bubble.
- XFER pop rule: rpop[gnt] = ~rempty[gnt] & ch_en[gnt] & adv & (beat < BURST). All other rpop bits are 0.
- On pop:
  - out_data <= rdata[gnt], out_ch <= gnt, out_valid <= 1, beat <= beat+1.
  - If beat == BURST-1: last <= gnt, go to IDLE.
- XFER release without pop:
  - Condition: rempty[gnt] or ~ch_en[gnt].
  - Action: last <= gnt, go to IDLE. Release takes priority over stall.
- XFER stall: rempty[gnt]=0, ch_en[gnt]=1, adv=0. Hold state, gnt and beat; no pop.
- Output register:
  - If out_valid & out_ready with no pop this cycle, out_valid <= 0.
  - Pop and accept in the same cycle: the new word loads, out_valid stays 1 (full throughput).
  - out_data and out_ch are stable while out_valid & ~out_ready.
- Latency:
  - First word reaches out_valid 2 cycles after elig rises: arbitrate, then pop.
  - Within a burst, sustained 1 word/cycle when out_ready=1.
- Channel ordering: words from one channel appear in FIFO order; no interleaving inside a grant.
- Round-robin fairness: a channel that stays eligible is granted within NCH arbitrations.
- ch_en changes take effect at the next IDLE scan or the next XFER cycle.
- busy = (state == XFER).

Test Plan:
- Single channel, BURST=4: ch0 holds 6 words (0x10..0x15), out_ready=1 → pops on 4 consecutive cycles; 1-cycle IDLE bubble; 2 more pops. out_data 0x10..0x15 in order, out_ch=0. After ch0 empties, state returns to IDLE and all rpop bits are 0.
- Round-robin: ch0 and ch2 each hold 8 words, ch1/ch3 empty, all enabled → grant order 0,2,0,2. Output order 4×ch0, 4×ch2, 4×ch0, 4×ch2. No pop to ch1 or ch3.
- Backpressure: ch1 holds 3 words, out_ready held low 5 cycles after the first out_valid → exactly 1 pop then stall. out_data is held constant. Release out_ready → remaining 2 pops on consecutive cycles; total 3 words delivered, none lost or duplicated.
- Empty mid-burst: ch3 holds 2 words, BURST=4 → 2 pops. XFER sees rempty[3]=1 and releases; last=3. The next arbitration starts its scan at ch0.
- Disable: ch2 granted with 8 words; ch_en[2] cleared after 2 pops → no further pop to ch2, return to IDLE. ch2 is never re-granted while disabled.
- Reset mid-burst: assert rrst for 1 cycle during the 3rd pop cycle of ch0 → rpop=0 that cycle. Next cycle: out_valid=0, busy=0, state IDLE. The first post-reset grant goes to ch0 (last=NCH-1).

Source files
------------

// File: rtl/fifo_rd_arbiter.sv
// Round-robin read scheduler draining NCH async-FIFO read ports into one
// registered valid/ready stream tagged with the source channel index.
module fifo_rd_arbiter #(
  parameter int NCH   = 4,
  parameter int DSIZE = 8,
  parameter int BURST = 4,
  localparam int CW   = $clog2(NCH),
  localparam int BW   = $clog2(BURST + 1)
) (
  input  logic                 rclk,
  input  logic                 rrst,
  input  logic [NCH-1:0]       ch_en,
  input  logic [NCH-1:0]       rempty,
  input  logic [NCH*DSIZE-1:0] rdata,
  output logic [NCH-1:0]       rpop,
  output logic [DSIZE-1:0]     out_data,
  output logic [CW-1:0]        out_ch,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy
);

  // Handshake: a word transfers downstream on any rising rclk where
  // out_valid & out_ready; out_data/out_ch hold while out_valid & ~out_ready.

  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

  localparam logic [BW-1:0] BURST_V  = BW'(BURST);
  localparam logic [BW-1:0] BURST_M1 = BW'(BURST - 1);
  localparam logic [CW-1:0] LAST_RST = CW'(NCH - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    gnt_q, gnt_d;
  logic [CW-1:0]    last_q, last_d;
  logic [BW-1:0]    beat_q, beat_d;
  logic             out_valid_q, out_valid_d;
  logic [DSIZE-1:0] out_data_q, out_data_d;
  logic [CW-1:0]    out_ch_q, out_ch_d;

  logic [NCH-1:0]   elig;
  logic             adv;
  logic [CW-1:0]    pick;
  logic             pick_found;
  logic [DSIZE-1:0] head_data;
  logic             pop;

  assign elig = ch_en & ~rempty;
  assign adv  = ~out_valid_q | out_ready;

  // Circular scan starting just after the last released grant.
  always_comb begin
    logic [CW-1:0] idx;
    pick       = '0;
    pick_found = 1'b0;
    idx        = '0;
    for (int k = 1; k <= NCH; k++) begin
      idx = CW'((int'(last_q) + k) % NCH);
      if (!pick_found && elig[idx]) begin
        pick_found = 1'b1;
        pick       = idx;
      end
    end
  end

  always_comb begin
    head_data = '0;
    for (int i = 0; i < NCH; i++) begin
      if (gnt_q == CW'(i)) head_data = rdata[i*DSIZE +: DSIZE];
    end
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    last_d      = last_q;
    beat_d      = beat_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    pop         = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          gnt_d   = pick;
          beat_d  = '0;
          state_d = XFER;
        end
      end
      XFER: begin
        // A drained or disabled channel releases even when the output is stalled.
        if (rempty[gnt_q] || !ch_en[gnt_q]) begin
          last_d  = gnt_q;
          state_d = IDLE;
        end else if (adv && (beat_q < BURST_V)) begin
          pop    = 1'b1;
          beat_d = beat_q + BW'(1);
          if (beat_q == BURST_M1) begin
            last_d  = gnt_q;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (pop) begin
      out_data_d  = head_data;
      out_ch_d    = gnt_q;
      out_valid_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      last_q      <= LAST_RST;
      beat_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      last_q      <= last_d;
      beat_q      <= beat_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
    end
  end

  assign rpop      = (pop && !rrst) ? (NCH'(1) << gnt_q) : '0;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q == XFER);

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Directed bench for fifo_rd_arbiter: FIFO models with registered empty flags
// feed the DUT, and an expected-word queue is checked as the stream drains.
module tb_fifo_rd_arbiter;
  localparam int NCH   = 4;
  localparam int DSIZE = 8;
  localparam int BURST = 4;
  localparam int CW    = 2;

  logic                 rclk = 1'b0;
  logic                 rrst = 1'b1;
  logic [NCH-1:0]       ch_en = '1;
  logic [NCH-1:0]       rempty_r = '1;
  logic [NCH*DSIZE-1:0] rdata_r = '0;
  logic [NCH-1:0]       rpop;
  logic [DSIZE-1:0]     out_data;
  logic [CW-1:0]        out_ch;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic                 busy;

  fifo_rd_arbiter #(.NCH(NCH), .DSIZE(DSIZE), .BURST(BURST)) dut (
    .rclk      (rclk),
    .rrst      (rrst),
    .ch_en     (ch_en),
    .rempty    (rempty_r),
    .rdata     (rdata_r),
    .rpop      (rpop),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  // clock / watchdog
  always #5 rclk = ~rclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  int n_tests = 0;
  int n_fail  = 0;
  logic [CW+DSIZE-1:0] exp_q[$];
  logic [CW+DSIZE-1:0] mon_e;
  logic [DSIZE-1:0]    fq [NCH][$];
  int pop_cnt [NCH] = '{default: 0};
  int bad_pop = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // FIFO read-side model: pop on rpop, empty flag and head word registered.
  always @(posedge rclk) begin
    if ((rpop & rempty_r) != '0) bad_pop++;
    if ($countones(rpop) > 1) bad_pop++;
    for (int i = 0; i < NCH; i++) begin
      if (rpop[i]) begin
        pop_cnt[i] = pop_cnt[i] + 1;
        if (fq[i].size() != 0) void'(fq[i].pop_front());
      end
    end
    for (int i = 0; i < NCH; i++) begin
      rempty_r[i] <= (fq[i].size() == 0);
      rdata_r[i*DSIZE +: DSIZE] <= (fq[i].size() != 0) ? fq[i][0] : '0;
    end
  end

  // scoreboard: compare every accepted output word
  always @(negedge rclk) begin
    if (!rrst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", {22'd0, out_ch, out_data}, 32'hFFFF_FFFF);
      end else begin
        mon_e = exp_q.pop_front();
        check("out_word", {22'd0, out_ch, out_data}, {22'd0, mon_e});
      end
    end
  end

  // driver tasks
  task automatic cyc();
    @(posedge rclk);
    #1;
  endtask

  task automatic push(input int ch, input logic [DSIZE-1:0] v);
    fq[ch].push_back(v);
  endtask

  task automatic exp_word(input int ch, input logic [DSIZE-1:0] v);
    exp_q.push_back({CW'(ch), v});
  endtask

  task automatic wait_drain(input int budget, input string tag);
    bit done;
    done = 1'b0;
    for (int k = 0; k < budget && !done; k++) begin
      cyc();
      @(negedge rclk);
      if (exp_q.size() == 0 && !out_valid && !busy) done = 1'b1;
    end
    check({tag, "_drain"}, {31'd0, done}, 32'd1);
  endtask

  task automatic wait_pop(input int ch, input int budget, input string tag);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge rclk);
      if (rpop[ch]) seen = 1'b1;
    end
    check({tag, "_first_pop"}, {31'd0, seen}, 32'd1);
  endtask

  task automatic do_reset();
    rrst = 1'b1;
    cyc();
    rrst = 1'b0;
  endtask

  int pat1 [11] = '{0, 0, 1, 1, 1, 1, 0, 1, 1, 0, 0};
  int base;

  initial begin
    // reset state
    repeat (2) cyc();
    @(negedge rclk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_rpop", {28'd0, rpop}, 32'd0);
    check("rst_out_data", {24'd0, out_data}, 32'd0);
    check("rst_out_ch", {30'd0, out_ch}, 32'd0);
    cyc();
    rrst = 1'b0;

    // single channel: 4-pop burst, bubble, 2 pops, release
    for (int i = 0; i < 6; i++) begin
      push(0, DSIZE'(8'h10 + i));
      exp_word(0, DSIZE'(8'h10 + i));
    end
    for (int k = 0; k < 11; k++) begin
      @(negedge rclk);
      check($sformatf("t1_rpop_c%0d", k), {28'd0, rpop}, (pat1[k] != 0) ? 32'd1 : 32'd0);
    end
    check("t1_idle_busy", {31'd0, busy}, 32'd0);
    check("t1_pop_cnt", pop_cnt[0], 32'd6);
    wait_drain(40, "t1");

    // round-robin between ch0 and ch2 from reset
    do_reset();
    base = pop_cnt[1] + pop_cnt[3];
    for (int i = 0; i < 8; i++) begin
      push(0, DSIZE'(8'h20 + i));
      push(2, DSIZE'(8'h30 + i));
    end
    for (int i = 0; i < 4; i++) exp_word(0, DSIZE'(8'h20 + i));
    for (int i = 0; i < 4; i++) exp_word(2, DSIZE'(8'h30 + i));
    for (int i = 4; i < 8; i++) exp_word(0, DSIZE'(8'h20 + i));
    for (int i = 4; i < 8; i++) exp_word(2, DSIZE'(8'h30 + i));
    wait_drain(100, "t2");
    check("t2_no_pop_ch1_ch3", pop_cnt[1] + pop_cnt[3], base);
    check("t2_pop_ch2", pop_cnt[2], 32'd8);

    // backpressure on ch1
    out_ready = 1'b0;
    base = pop_cnt[1];
    for (int i = 0; i < 3; i++) begin
      push(1, DSIZE'(8'h40 + i));
      exp_word(1, DSIZE'(8'h40 + i));
    end
    begin
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
        @(negedge rclk);
        if (out_valid) seen = 1'b1;
      end
      check("t3_first_valid", {31'd0, seen}, 32'd1);
    end
    for (int k = 0; k < 5; k++) begin
      check("t3_hold_data", {24'd0, out_data}, 32'h40);
      check("t3_stall_rpop", {28'd0, rpop}, 32'd0);
      check("t3_stall_busy", {31'd0, busy}, 32'd1);
      @(negedge rclk);
    end
    check("t3_single_pop", pop_cnt[1] - base, 32'd1);
    cyc();
    out_ready = 1'b1;
    @(negedge rclk);
    check("t3_pop2", {28'd0, rpop}, 32'b0010);
    @(negedge rclk);
    check("t3_pop3", {28'd0, rpop}, 32'b0010);
    @(negedge rclk);
    check("t3_after_empty", {28'd0, rpop}, 32'd0);
    wait_drain(30, "t3");
    check("t3_total_pops", pop_cnt[1] - base, 32'd3);

    // empty mid-burst on ch3, then scan resumes at ch0
    base = pop_cnt[3];
    push(3, 8'h50); exp_word(3, 8'h50);
    push(3, 8'h51); exp_word(3, 8'h51);
    wait_drain(30, "t4a");
    check("t4_ch3_pops", pop_cnt[3] - base, 32'd2);
    push(0, 8'h60); push(2, 8'h70);
    exp_word(0, 8'h60); exp_word(2, 8'h70);
    wait_drain(30, "t4b");

    // disable ch2 mid-burst
    base = pop_cnt[2];
    for (int i = 0; i < 8; i++) push(2, DSIZE'(8'h80 + i));
    exp_word(2, 8'h80); exp_word(2, 8'h81);
    wait_pop(2, 20, "t5");
    cyc();
    cyc();
    ch_en[2] = 1'b0;
    wait_drain(30, "t5a");
    check("t5_two_pops", pop_cnt[2] - base, 32'd2);
    push(1, 8'h90); exp_word(1, 8'h90);
    wait_drain(30, "t5b");
    repeat (10) cyc();
    @(negedge rclk);
    check("t5_no_regrant", pop_cnt[2] - base, 32'd2);
    check("t5_idle_busy", {31'd0, busy}, 32'd0);
    ch_en[2] = 1'b1;
    for (int i = 2; i < 8; i++) exp_word(2, DSIZE'(8'h80 + i));
    wait_drain(40, "t5c");
    check("t5_all_pops", pop_cnt[2] - base, 32'd8);

    // reset during the 3rd pop of a ch0 burst
    for (int i = 0; i < 8; i++) push(0, DSIZE'(8'hA0 + i));
    for (int i = 0; i < 4; i++) push(1, DSIZE'(8'hB0 + i));
    exp_word(0, 8'hA0);
    wait_pop(0, 20, "t6");
    cyc();
    cyc();
    rrst = 1'b1;
    @(negedge rclk);
    check("t6_rpop_in_reset", {28'd0, rpop}, 32'd0);
    cyc();
    rrst = 1'b0;
    for (int i = 2; i < 6; i++) exp_word(0, DSIZE'(8'hA0 + i));
    for (int i = 0; i < 4; i++) exp_word(1, DSIZE'(8'hB0 + i));
    for (int i = 6; i < 8; i++) exp_word(0, DSIZE'(8'hA0 + i));
    @(negedge rclk);
    check("t6_out_valid", {31'd0, out_valid}, 32'd0);
    check("t6_busy", {31'd0, busy}, 32'd0);
    check("t6_idle_rpop", {28'd0, rpop}, 32'd0);
    @(negedge rclk);
    check("t6_first_grant", {28'd0, rpop}, 32'b0001);
    wait_drain(60, "t6");

    check("bad_pop_count", bad_pop, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
